// File: rtl/serial_add_unit_pkg.sv
// ============================================================================
// serial_add_unit_pkg : shared state encoding and default widths
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_add_unit_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_unit_if.sv
// ============================================================================
// serial_add_unit_if : start/done handshake plus serial link to accumulator
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_add_unit_if
  import serial_add_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] addend;
  logic             acc_bit;
  logic             sum_bit;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic             cout;

  modport master (
    output start, sub, addend, acc_bit,
    input  sum_bit, shift_en, busy, done, cout
  );

  modport slave (
    input  start, sub, addend, acc_bit,
    output sum_bit, shift_en, busy, done, cout
  );

endinterface

`default_nettype wire

// File: rtl/serial_add_unit_full_adder_bit.sv
// ============================================================================
// full_adder_bit : combinational one-bit sum / majority cell
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder_bit
  import serial_add_unit_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

`default_nettype wire

// File: rtl/serial_add_unit.sv
// ============================================================================
// serial_add_unit : bit-serial add/subtract stage driving an accumulator
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_add_unit
  import serial_add_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic               clk_i,
  input  logic               rst_i,
  serial_add_unit_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] addend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             shift_en_q;
  logic             busy_q;
  logic             done_q;
  logic             sum_d;
  logic             carry_d;

  full_adder_bit u_fa (
    .a_i     (bus.acc_bit),
    .b_i     (addend_q[0]),
    .c_i     (carry_q),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addend_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtraction is acc + ~addend + 1: invert here, seed carry with 1
            addend_q   <= bus.sub ? ~bus.addend : bus.addend;
            carry_q    <= bus.sub;
            cnt_q      <= '0;
            state_q    <= S_SHIFT;
            shift_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_SHIFT: begin
          carry_q  <= carry_d;
          addend_q <= {1'b0, addend_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q    <= S_DONE;
            cout_q     <= carry_d;
            shift_en_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          shift_en_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum_bit  = shift_en_q & sum_d;
  assign bus.shift_en = shift_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cout     = cout_q;

endmodule

`default_nettype wire

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial adder/subtractor stage that consumes accumulator_shift_reg's serial output (Sout) and returns the sum bit to its serial input (Si), LSB first.
- Holds the addend in an internal shift register, keeps a carry flip-flop, and counts WIDTH shifts under a small FSM with a start/done handshake.
- Drives the accumulator's shift enable so the accumulator holds the result after WIDTH cycles.

Parameters:
- WIDTH, 8, operand width in bits; also the number of shift cycles per operation.
- CNT_W, 3, counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- CLK  input  1  rising-edge clock, shared with accumulator_shift_reg.
- RST  input  1  synchronous reset, active-high.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (acc - addend); captured with start.
- addend  input  WIDTH  parallel addend; captured with start.
- acc_bit  input  1  serial bit from accumulator Sout (current accumulator LSB).
- sum_bit  output  1  serial result bit to accumulator Si.
- shift_en  output  1  accumulator shift enable; high for exactly WIDTH cycles per operation.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when the result is complete.
- cout  output  1  final carry; for sub, 1 = no borrow. Held until the next start.

Behaviour:
- Reset (RST=1 at a rising edge):
  - State -> IDLE; counter, carry, addend register and cout -> 0.
  - shift_en, busy, done -> 0. sum_bit -> 0, because it is gated by SHIFT.
  - Reset overrides every other input, including mid-SHIFT. The partially shifted accumulator is abandoned, and no done pulse is generated.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Outputs: shift_en=0, busy=0, done=0.
  - On an edge with start=1:
    - addend register <= (sub ? ~addend : addend).
    - carry <= sub.
    - counter <= 0.
    - state -> SHIFT.
  - start=0: remain in IDLE; cout holds its value.
- SHIFT:
  - Outputs: shift_en=1, busy=1.
  - sum_bit = acc_bit ^ a0 ^ carry, combinational, where a0 = addend register LSB.
  - Each edge:
    - carry <= majority(acc_bit, a0, carry).
    - addend register shifts right, with 0 filled at the MSB.
    - counter increments.
  - On the edge where counter == WIDTH-1, state -> DONE and cout <= the carry computed on that edge.
  - Exactly WIDTH SHIFT cycles occur.
- DONE:
  - Outputs: done=1 and busy=1 for one cycle, shift_en=0, sum_bit=0.
  - Next state is always IDLE.
  - start in DONE is ignored.
- Latency:
  - start is sampled at edge k.
  - shift_en is high for cycles k+1 through k+WIDTH.
  - done is high during cycle k+WIDTH+1.
  - With start held high, a new operation begins every WIDTH+2 cycles.
- start and sub/addend changes are ignored while busy=1; captured values are frozen for the whole operation.
- Arithmetic: modulo 2**WIDTH; the overflow/borrow indication is cout only, with no signed-overflow flag.
- acc_bit is a don't-care outside SHIFT.
- Interface contract: the accumulator shifts on every edge where shift_en=1, taking Si=sum_bit. It must not be loaded (L=1) while busy=1.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2) and the default WIDTH.
- One natural sub-module: full_adder_bit, a combinational sum/majority cell instantiated once. The carry flip-flop stays in serial_add_unit.
- The bench pairs serial_add_unit with accumulator_shift_reg, gating the accumulator clock-enable with shift_en.

Test Plan:
- Reset: RST=1 for 2 cycles with start=1 -> shift_en=busy=done=cout=sum_bit=0, state IDLE; start is ignored while RST=1.
- Add: acc=0xA4, addend=0x01, sub=0 -> sum_bit LSB-first 1,0,1,0,0,1,0,1 on 8 shift_en cycles; done at cycle k+9; acc=0xA5; cout=0.
- Add with carry out: acc=0xA4, addend=0x5C -> acc=0x00, cout=1, done a single-cycle pulse.
- Subtract: acc=0xA4, addend=0x24, sub=1 -> acc=0x80, cout=1. Then acc=0x24, addend=0xA4, sub=1 -> acc=0x80, cout=0 (borrow).
- Interference and reset: start toggled and addend changed to 0xFF during SHIFT -> result unaffected. Separate run: RST=1 at the 3rd shift cycle -> next cycle IDLE, carry=0, no done. A following 0x10+0x20 operation yields 0x30.
- Back-to-back: start held high for three operations -> done pulses exactly 10 cycles apart, shift_en low in each DONE and IDLE gap cycle.
